// File: rtl/selftrigger_pkg.sv
// Shared definitions for the self-triggered record capture block:
// FSM state encoding, header constants and small helper functions.
package selftrigger_pkg;

  localparam logic [7:0]  HDR_MARKER = 8'hA5;
  localparam int unsigned HDR_LEN    = 4;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HEADER  = 3'd3,
    ST_DATA    = 3'd4
  } state_t;

  // Saturating 16-bit increment used by both event counters
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Header word selector: marker+count, then timestamp high/mid/low
  function automatic logic [15:0] header_word(input logic [1:0]  idx,
                                              input logic [7:0]  cnt,
                                              input logic [47:0] ts);
    case (idx)
      2'd0:    return {HDR_MARKER, cnt};
      2'd1:    return ts[47:32];
      2'd2:    return ts[31:16];
      default: return ts[15:0];
    endcase
  endfunction

endpackage

// File: rtl/selftrigger_ring_ram.sv
// Simple dual-port ring buffer with one-cycle registered read.
// Read data holds when rd_en is low, which the readout pipeline relies on
// to keep the fetched sample stable across downstream stalls.
module selftrigger_ring_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/selftrigger_record_capture.sv
// Self-triggered record capture: keeps a pre-trigger history in a ring
// buffer, captures the post-trigger samples on a trigger rising edge and
// streams a 4-word header followed by the record over a valid/ready port.
module selftrigger_record_capture
  import selftrigger_pkg::*;
#(
  parameter int unsigned PRE_SAMPLES = 64,
  parameter int unsigned RECORD_LEN  = 256,
  parameter int unsigned BUF_AW      = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic signed [15:0] baseline,
  input  logic               trigger,
  input  logic [47:0]        timestamp,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [15:0]        trigger_count,
  output logic [15:0]        dropped_count
);

  localparam int unsigned POST_LEN = RECORD_LEN - PRE_SAMPLES;
  localparam int unsigned TOTAL    = HDR_LEN + RECORD_LEN;
  localparam int unsigned FILL_W   = $clog2(PRE_SAMPLES + 2);
  localparam int unsigned CAP_W    = $clog2(RECORD_LEN + 1);
  localparam int unsigned IDX_W    = $clog2(TOTAL + 1);

  state_t              state;
  logic [BUF_AW-1:0]   wr_ptr;
  logic [BUF_AW-1:0]   start_addr;
  logic [FILL_W-1:0]   fill_cnt;
  logic [CAP_W-1:0]    cap_cnt;
  logic [IDX_W-1:0]    rd_idx;
  logic                trig_q;
  logic [47:0]         ts_lat;
  logic [15:0]         baseline_lat_unused;  // latched with the record, not emitted in this header format
  logic [7:0]          hdr_cnt;
  logic                s1_valid;
  logic                s1_ram;
  logic                s1_last;
  logic [15:0]         s1_hdr;
  logic [15:0]         ram_q;

  logic                trig_evt;
  logic                wr_en;
  logic                rd_phase;
  logic                adv;
  logic                issue;
  logic                done_xfer;
  logic [BUF_AW-1:0]   rd_addr;
  logic [FILL_W-1:0]   fill_inc;
  logic [CAP_W-1:0]    cap_inc;

  assign trig_evt  = trigger && !trig_q;
  assign wr_en     = enable && (state inside {ST_FILL, ST_ARMED, ST_CAPTURE});
  assign rd_phase  = (state == ST_HEADER) || (state == ST_DATA);
  assign adv       = !out_valid || out_ready;
  assign issue     = adv && rd_phase && (rd_idx < IDX_W'(TOTAL));
  assign done_xfer = out_valid && out_ready && out_last;
  assign rd_addr   = start_addr + BUF_AW'(rd_idx - IDX_W'(HDR_LEN));
  assign fill_inc  = fill_cnt + 1'b1;
  assign cap_inc   = cap_cnt + 1'b1;

  selftrigger_ring_ram #(.AW(BUF_AW), .DW(16)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (x),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Capture FSM: fill, arm, capture, then hand off to the readout phases
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_FILL;
      busy                <= 1'b0;
      wr_ptr              <= '0;
      start_addr          <= '0;
      fill_cnt            <= '0;
      cap_cnt             <= '0;
      trig_q              <= 1'b0;
      ts_lat              <= '0;
      baseline_lat_unused <= '0;
      hdr_cnt             <= '0;
      trigger_count       <= '0;
      dropped_count       <= '0;
    end else begin
      trig_q <= trigger;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (trig_evt && enable && (state != ST_ARMED))
        dropped_count <= sat_inc(dropped_count);

      case (state)
        ST_FILL: begin
          if (!enable) begin
            fill_cnt <= '0;
          end else if (fill_inc >= FILL_W'(PRE_SAMPLES)) begin
            fill_cnt <= fill_inc;
            state    <= ST_ARMED;
          end else begin
            fill_cnt <= fill_inc;
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            fill_cnt <= '0;
            state    <= ST_FILL;
          end else if (trig_evt) begin
            start_addr          <= wr_ptr - BUF_AW'(PRE_SAMPLES);
            ts_lat              <= timestamp;
            baseline_lat_unused <= baseline;
            trigger_count       <= sat_inc(trigger_count);
            hdr_cnt             <= 8'(sat_inc(trigger_count));
            cap_cnt             <= CAP_W'(1);
            busy                <= 1'b1;
            state               <= (POST_LEN == 1) ? ST_HEADER : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!enable) begin
            fill_cnt <= '0;
            busy     <= 1'b0;
            state    <= ST_FILL;
          end else begin
            cap_cnt <= cap_inc;
            if (cap_inc == CAP_W'(POST_LEN)) state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (issue && (rd_idx == IDX_W'(HDR_LEN - 1))) state <= ST_DATA;
        end
        ST_DATA: begin
          if (done_xfer) begin
            fill_cnt <= '0;
            busy     <= 1'b0;
            state    <= ST_FILL;
          end
        end
        default: begin
          fill_cnt <= '0;
          busy     <= 1'b0;
          state    <= ST_FILL;
        end
      endcase
    end
  end

  // Two-stage readout (fetch, output register) that stalls as a unit
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx    <= '0;
      s1_valid  <= 1'b0;
      s1_ram    <= 1'b0;
      s1_last   <= 1'b0;
      s1_hdr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (adv) begin
        out_valid <= s1_valid;
        out_last  <= s1_valid && s1_last;
        if (s1_valid) out_data <= s1_ram ? ram_q : s1_hdr;
        s1_valid <= issue;
        s1_ram   <= (rd_idx >= IDX_W'(HDR_LEN));
        s1_last  <= (rd_idx == IDX_W'(TOTAL - 1));
        s1_hdr   <= header_word(rd_idx[1:0], hdr_cnt, ts_lat);
        if (issue) rd_idx <= rd_idx + 1'b1;
      end
      if (done_xfer) rd_idx <= '0;
    end
  end

endmodule

// File: tb/tb_selftrigger_record_capture.sv
// Scoreboard bench for selftrigger_record_capture: x is a ramp, so the
// expected record for a trigger at sample T is T-64..T+191 behind a header.
module tb_selftrigger_record_capture;

  localparam int unsigned PRE = 64;
  localparam int unsigned LEN = 256;
  localparam logic [47:0] TS_BASE = 48'hABCD_1234_0000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic signed [15:0] x = '0;
  logic signed [15:0] baseline = 16'sh0100;
  logic               trigger = 1'b0;
  logic [47:0]        timestamp = TS_BASE;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_last;
  logic               busy;
  logic [15:0]        trigger_count;
  logic [15:0]        dropped_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_popped = 0;
  int          cyc = 0;
  bit          tog = 1'b0;
  logic [16:0] sb_q[$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  selftrigger_record_capture #(
    .PRE_SAMPLES (PRE),
    .RECORD_LEN  (LEN),
    .BUF_AW      (9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .x             (x),
    .baseline      (baseline),
    .trigger       (trigger),
    .timestamp     (timestamp),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .trigger_count (trigger_count),
    .dropped_count (dropped_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one sample: ramp x and timestamp, end any trigger pulse
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    x         = x + 16'sd1;
    timestamp = TS_BASE + 48'(cyc);
    trigger   = 1'b0;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic run_to(input logic [15:0] v);
    for (int i = 0; i < 5000 && x != v; i++) tick();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise trigger for the current sample; queue the expected record if accepted
  task automatic pulse(input bit accept, input logic [7:0] cnt);
    logic [15:0] d;
    trigger = 1'b1;
    if (accept) begin
      sb_q.push_back({1'b0, 8'hA5, cnt});
      sb_q.push_back({1'b0, timestamp[47:32]});
      sb_q.push_back({1'b0, timestamp[31:16]});
      sb_q.push_back({1'b0, timestamp[15:0]});
      for (int i = 0; i < int'(LEN); i++) begin
        d = x - 16'(PRE) + 16'(i);
        sb_q.push_back({(i == int'(LEN) - 1), d});
      end
    end
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((busy || sb_q.size() != 0) && i < 3000) begin
      tick();
      i++;
    end
    check({tag, "_drained"}, 32'(i < 3000), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    x     = '0;
  endtask

  // Output monitor: pops the scoreboard on each transfer, checks stall hold
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 32'({out_last, out_data}), 32'hFFFF_FFFF);
        end else begin
          check("word", 32'({out_last, out_data}), 32'(sb_q.pop_front()));
          n_popped++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    int base;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tcnt", 32'(trigger_count), 32'd0);
    check("rst_dcnt", 32'(dropped_count), 32'd0);
    reset = 1'b0;
    x     = '0;

    // Ramp record at 1000, drop in CAPTURE and in DATA
    run_to(16'd1000);
    pulse(1'b1, 8'd1);
    check("busy_capture", 32'(busy), 32'd1);
    run_to(16'd1010);
    pulse(1'b0, 8'd0);
    run_to(16'd1300);
    check("busy_data", 32'(busy), 32'd1);
    pulse(1'b0, 8'd0);
    wait_idle("rec1");
    check("rec1_tcnt", 32'(trigger_count), 32'd1);
    check("rec1_dcnt", 32'(dropped_count), 32'd2);
    check("rec1_busy", 32'(busy), 32'd0);

    // Readout with out_ready toggling every cycle
    run_n(80);
    tog = 1'b1;
    pulse(1'b1, 8'd2);
    wait_idle("toggle");
    tog       = 1'b0;
    out_ready = 1'b1;
    check("toggle_tcnt", 32'(trigger_count), 32'd2);

    // Trigger during FILL dropped, later one accepted
    do_reset();
    check("fillrst_tcnt", 32'(trigger_count), 32'd0);
    run_to(16'd30);
    pulse(1'b0, 8'd0);
    run_to(16'd200);
    pulse(1'b1, 8'd1);
    wait_idle("fill");
    check("fill_dcnt", 32'(dropped_count), 32'd1);
    check("fill_tcnt", 32'(trigger_count), 32'd1);

    // Write pointer near 511: record wraps across address 0
    do_reset();
    run_to(16'd505);
    pulse(1'b1, 8'd1);
    wait_idle("wrap");
    check("wrap_dcnt", 32'(dropped_count), 32'd0);

    // Reset mid-DATA, then a clean record after refill
    run_n(80);
    base = n_popped;
    pulse(1'b1, 8'd2);
    for (int i = 0; i < 1000 && n_popped < base + 100; i++) tick();
    check("middata_reached", 32'(n_popped >= base + 100), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_tcnt", 32'(trigger_count), 32'd0);
    sb_q.delete();
    reset = 1'b0;
    run_n(100);
    pulse(1'b1, 8'd1);
    wait_idle("after_rst");
    check("after_rst_tcnt", 32'(trigger_count), 32'd1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/selftrigger_record_capture.md
SELFTRIGGER_RECORD_CAPTURE -- requirements
Module: selftrigger_record_capture

Interface
REQ-001 Parameters SHALL be (name, default, meaning): PRE_SAMPLES, 64, samples kept before the trigger; RECORD_LEN, 256, total samples per record; BUF_AW, 9, ring-buffer address width; legal only for PRE_SAMPLES < RECORD_LEN <= 2^BUF_AW.
REQ-002 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  single clock, one sample per cycle;
 reset  in  1  synchronous, active-high;
 enable  in  1  capture enable;
 x  in  16 signed  sample stream, time-aligned with trigger;
 baseline  in  16 signed  filter baseline;
 trigger  in  1  self-trigger level;
 timestamp  in  48  free-running sample timestamp;
 out_data  out  16  record word;
 out_valid  out  1  word valid;
 out_ready  in  1  downstream accepts;
 out_last  out  1  final word of record;
 busy  out  1  high in CAPTURE, HEADER, DATA;
 trigger_count  out  16  accepted records;
 dropped_count  out  16  rejected trigger events.

Function
REQ-003 A trigger event SHALL be a rising edge: trigger=1 with the trigger value registered on the previous cycle = 0.
REQ-004 States SHALL be FILL, ARMED, CAPTURE, HEADER, DATA.
REQ-005 In FILL, ARMED and CAPTURE with enable=1, x SHALL be written to the ring buffer every cycle; the write pointer increments and wraps modulo 2^BUF_AW.
REQ-006 FILL SHALL count written samples and move to ARMED when the count reaches PRE_SAMPLES.
REQ-007 In ARMED, a trigger event SHALL latch timestamp, baseline and start address (write pointer minus PRE_SAMPLES, modulo), increment trigger_count and enter CAPTURE. The trigger-cycle sample SHALL be record index PRE_SAMPLES.
REQ-008 CAPTURE SHALL write RECORD_LEN-PRE_SAMPLES samples, trigger sample included, then enter HEADER; buffer writes stop from that point.
REQ-009 HEADER SHALL emit 4 words: {8'hA5, trigger_count[7:0] of this record}, timestamp[47:32], [31:16], [15:0].
REQ-010 DATA SHALL emit RECORD_LEN samples in index order from the start address, wrapping, and assert out_last on the final sample. It SHALL then enter FILL with the fill count cleared.
REQ-011 Handshake: a word transfers when out_valid && out_ready. While out_valid=1 && out_ready=0, out_data and out_last SHALL hold stable. out_valid SHALL NOT depend combinationally on out_ready.
REQ-012 At out_ready=1 held, HEADER+DATA SHALL produce one word per cycle after at most 1 cycle of initial RAM-read latency.
REQ-013 A trigger event with enable=1 in FILL, CAPTURE, HEADER or DATA SHALL increment dropped_count. Both counters SHALL saturate at 16'hFFFF.
REQ-014 enable=0 in FILL, ARMED or CAPTURE SHALL stop writes and force FILL with the fill count cleared at the next edge, abandoning any partial capture. trigger_count SHALL NOT be decremented.
REQ-015 enable=0 in HEADER or DATA SHALL NOT interrupt the record. Trigger events while enable=0 SHALL be ignored and not counted.

Reset
REQ-016 reset SHALL force FILL, clear the pointers, fill count, both counters and the trigger edge register, and drive out_valid=0, out_last=0, out_data=0, busy=0 on the following cycle.
REQ-017 reset SHALL override everything mid-record; the buffer contents need not be cleared.

Structure
REQ-018 The header marker 8'hA5, the header length 4 and the state encoding SHALL live in the shared selftrigger package.
REQ-019 The ring buffer SHALL be a separate sub-module, selftrigger_ring_ram: simple dual-port, 1-cycle registered read, block-RAM inferable.

Verification
REQ-020 Ramp x=0,1,2,..., trigger pulse at x=1000, out_ready=1 -> header {A5,01}, timestamp words; data 936..1191; out_last on 1191.
REQ-021 Second pulse 10 cycles after the first, and a pulse during DATA -> dropped_count=2, trigger_count=1.
REQ-022 out_ready toggling 1/0 every cycle during readout -> identical 260-word sequence, no word lost or duplicated.
REQ-023 Trigger 30 cycles after reset release -> FILL drop, dropped_count=1; pulse at cycle 200 -> accepted.
REQ-024 Write pointer near 511 at trigger -> data wraps correctly across address 0.
REQ-025 reset asserted mid-DATA -> out_valid=0 next cycle; FILL; next record is correct after 64 fill samples.
